addsub_seq_ctrl: RTL



---
 rtl/addsub_seq_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/addsub_seq_ctrl.sv
// Multi-nibble add/subtract sequencer: one 4-bit slice per clock, LSB first.
// Optional zero flag output enabled by defining ADDSUB_SEQ_ZERO_EN.
module addsub_seq_ctrl #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         select,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out,
`ifdef ADDSUB_SEQ_ZERO_EN
  output logic         overflow,
  output logic         zero
`else
  output logic         overflow
`endif
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          sel_q;
  logic [IW-1:0] idx;
  logic          c;
  logic [W-1:0]  shadow;

  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [4:0]    sum5;
  logic [4:0]    dif5;
  logic [3:0]    r;
  logic          c_nxt;
  logic [W-1:0]  shadow_nxt;

  logic          load;
  logic          step;
  logic          last;

  // a start is honoured only outside RUN; operands stay frozen during a run
  assign load = start && (state != RUN);
  assign step = (state == RUN);
  assign last = step && (idx == LAST);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode; RUN exits on the last nibble so idx never wraps
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // select the current nibble pair from the latched operands
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx == IW'(k)) begin
        a_nib = a_q[4*k +: 4];
        b_nib = b_q[4*k +: 4];
      end
    end
  end

  // 4-bit slice: carry chain for add, borrow chain for subtract
  always_comb begin
    sum5 = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, c};
    dif5 = {1'b1, a_nib} - {1'b0, b_nib} - {4'b0, c};
    if (sel_q) begin
      r     = sum5[3:0];
      c_nxt = sum5[4];
    end else begin
      r     = dif5[3:0];
      c_nxt = ~dif5[4];
    end
  end

  // shadow result with the current nibble merged in
  always_comb begin
    shadow_nxt = shadow;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx == IW'(k)) shadow_nxt[4*k +: 4] = r;
    end
  end

  // operand latch, nibble index, chain bit and shadow result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sel_q  <= 1'b0;
      idx    <= '0;
      c      <= 1'b0;
      shadow <= '0;
    end else if (load) begin
      a_q   <= A;
      b_q   <= B;
      sel_q <= select;
      idx   <= '0;
      c     <= 1'b0;
    end else if (step) begin
      shadow <= shadow_nxt;
      c      <= c_nxt;
      if (!last) idx <= idx + 1'b1;
    end
  end

  // visible result updates only when the final nibble completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out      <= '0;
      overflow <= 1'b0;
    end else if (last) begin
      out      <= shadow_nxt;
      overflow <= c_nxt;
    end
  end

`ifdef ADDSUB_SEQ_ZERO_EN
  // zero flag tracks the published result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero <= 1'b1;
    end else if (last) begin
      zero <= (shadow_nxt == '0);
    end
  end
`endif

endmodule
